// File: rtl/fifo_sync.sv
// Synchronous 8 x 32 FIFO with registered read data, per-request ack/err pulses
// and combinational full/empty/data_count decoded from the stored word count.
module fifo_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [CNT_WIDTH-1:0]  data_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    // Request classification for one edge, judged against the pre-edge count.
    localparam logic [2:0] OP_NO_OP   = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_WR_ERR  = 3'd2;
    localparam logic [2:0] OP_READ    = 3'd3;
    localparam logic [2:0] OP_RD_ERR  = 3'd4;
    localparam logic [2:0] OP_BOTH    = 3'd5;
    localparam logic [2:0] OP_BOTH_E  = 3'd6;
    localparam logic [2:0] OP_BOTH_F  = 3'd7;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;

    logic [2:0] op;
    logic       do_write;
    logic       do_read;
    logic       reject_write;
    logic       reject_read;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign data_count = count;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        op           = OP_NO_OP;
        do_write     = 1'b0;
        do_read      = 1'b0;
        reject_write = 1'b0;
        reject_read  = 1'b0;

        unique case ({wr_en, rd_en})
            2'b10:   op = full  ? OP_WR_ERR : OP_WRITE;
            2'b01:   op = empty ? OP_RD_ERR : OP_READ;
            2'b11:   op = empty ? OP_BOTH_E : (full ? OP_BOTH_F : OP_BOTH);
            default: op = OP_NO_OP;
        endcase

        case (op)
            OP_WRITE:  do_write = 1'b1;
            OP_WR_ERR: reject_write = 1'b1;
            OP_READ:   do_read = 1'b1;
            OP_RD_ERR: reject_read = 1'b1;
            OP_BOTH: begin
                do_write = 1'b1;
                do_read  = 1'b1;
            end
            // Empty: the word is stored but not bypassed to d_out.
            OP_BOTH_E: begin
                do_write    = 1'b1;
                reject_read = 1'b1;
            end
            // Full: fullness is judged before the read frees a slot.
            OP_BOTH_F: begin
                do_read      = 1'b1;
                reject_write = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: storage has no reset; pointers and count alone define which words are valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= d_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            d_out  <= '0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_ack <= do_write;
            wr_err <= reject_write;
            rd_ack <= do_read;
            rd_err <= reject_read;

            if (do_write) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_read) begin
                d_out  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end

            unique case ({do_write, do_read})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: fill, overflow, drain, underflow, wrap with
// simultaneous traffic, asynchronous reset and the both-request boundaries.
module tb_fifo_sync;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [3:0]  data_count;

    int total = 0;
    int bad   = 0;

    logic [9:0] status;

    fifo_sync dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .d_in       (d_in),
        .d_out      (d_out),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count)
    );

    always #5 clk = ~clk;

    // Status vector layout: {full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count}
    assign status = {full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count};

    function automatic logic [9:0] st(input logic f, input logic e, input logic wa,
                                      input logic we, input logic ra, input logic re,
                                      input int cnt);
        return {f, e, wa, we, ra, re, 4'(cnt)};
    endfunction

    // Drive one request away from the edge, then sample just after the edge.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (status !== st(0, 1, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_status got=%b want=%b", status, st(0, 1, 0, 0, 0, 0, 0));
        end
        total++;
        if (d_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_dout got=%h want=%h", d_out, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 32'h1111_1111 * i);
            total++;
            if (status !== st(i == 7, 0, 1, 0, 0, 0, i + 1)) begin
                bad++;
                $display("FAIL fill[%0d] got=%b want=%b", i, status, st(i == 7, 0, 1, 0, 0, 0, i + 1));
            end
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 32'h8888_8888);
        total++;
        if (status !== st(1, 0, 0, 1, 0, 0, 8)) begin
            bad++;
            $display("FAIL overflow_a got=%b want=%b", status, st(1, 0, 0, 1, 0, 0, 8));
        end
        step(1, 0, 32'h9999_9999);
        total++;
        if (status !== st(1, 0, 0, 1, 0, 0, 8)) begin
            bad++;
            $display("FAIL overflow_b got=%b want=%b", status, st(1, 0, 0, 1, 0, 0, 8));
        end
        step(0, 0, 32'h0);
        total++;
        if (status !== st(1, 0, 0, 0, 0, 0, 8)) begin
            bad++;
            $display("FAIL idle_clears got=%b want=%b", status, st(1, 0, 0, 0, 0, 0, 8));
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32'h0);
            total++;
            if (d_out !== 32'h1111_1111 * i) begin
                bad++;
                $display("FAIL drain_data[%0d] got=%h want=%h", i, d_out, 32'h1111_1111 * i);
            end
            total++;
            if (status !== st(0, i == 7, 0, 0, 1, 0, 7 - i)) begin
                bad++;
                $display("FAIL drain_status[%0d] got=%b want=%b", i, status, st(0, i == 7, 0, 0, 1, 0, 7 - i));
            end
        end
    endtask

    task automatic test_underflow();
        step(0, 1, 32'h0);
        total++;
        if (status !== st(0, 1, 0, 0, 0, 1, 0)) begin
            bad++;
            $display("FAIL underflow_status got=%b want=%b", status, st(0, 1, 0, 0, 0, 1, 0));
        end
        total++;
        if (d_out !== 32'h7777_7777) begin
            bad++;
            $display("FAIL underflow_dout got=%h want=%h", d_out, 32'h7777_7777);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'hA000_0000 + i);
            total++;
            if (status !== st(0, 0, 1, 0, 0, 0, i + 1)) begin
                bad++;
                $display("FAIL wrap_prefill[%0d] got=%b want=%b", i, status, st(0, 0, 1, 0, 0, 0, i + 1));
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 32'hA000_0003 + k);
            total++;
            if (d_out !== 32'hA000_0000 + k) begin
                bad++;
                $display("FAIL wrap_data[%0d] got=%h want=%h", k, d_out, 32'hA000_0000 + k);
            end
            total++;
            if (status !== st(0, 0, 1, 0, 1, 0, 3)) begin
                bad++;
                $display("FAIL wrap_status[%0d] got=%b want=%b", k, status, st(0, 0, 1, 0, 1, 0, 3));
            end
        end
    endtask

    task automatic test_async_reset();
        // Acks from the last simultaneous edge are still high here; reset must drop them at once.
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (status !== st(0, 1, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL async_reset_status got=%b want=%b", status, st(0, 1, 0, 0, 0, 0, 0));
        end
        total++;
        if (d_out !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_dout got=%h want=%h", d_out, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_both_boundaries();
        step(1, 1, 32'hCAFE_0000);
        total++;
        if (status !== st(0, 0, 1, 0, 0, 1, 1)) begin
            bad++;
            $display("FAIL both_empty_status got=%b want=%b", status, st(0, 0, 1, 0, 0, 1, 1));
        end
        total++;
        if (d_out !== 32'h0) begin
            bad++;
            $display("FAIL both_empty_no_bypass got=%h want=%h", d_out, 32'h0);
        end
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 32'hB000_0000 + i);
        end
        total++;
        if (status !== st(1, 0, 1, 0, 0, 0, 8)) begin
            bad++;
            $display("FAIL refill_status got=%b want=%b", status, st(1, 0, 1, 0, 0, 0, 8));
        end
        step(1, 1, 32'hDEAD_BEEF);
        total++;
        if (status !== st(0, 0, 0, 1, 1, 0, 7)) begin
            bad++;
            $display("FAIL both_full_status got=%b want=%b", status, st(0, 0, 0, 1, 1, 0, 7));
        end
        total++;
        if (d_out !== 32'hCAFE_0000) begin
            bad++;
            $display("FAIL both_full_data got=%h want=%h", d_out, 32'hCAFE_0000);
        end
        step(0, 1, 32'h0);
        total++;
        if (d_out !== 32'hB000_0000) begin
            bad++;
            $display("FAIL after_both_full_data got=%h want=%h", d_out, 32'hB000_0000);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_wrap();
        test_async_reset();
        test_both_boundaries();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
